irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
// - Interrupt controller feeding the s1c88 irq input inside minx.
// - Edge-latches up to 32 interrupt sources (prc frame_copy/render_done, timers, keys, ...) into flag registers.
// - Masks flags by enable bits and per-group 2-bit priority.
// - Presents the winning priority level and vector number to the CPU.
// - Sits on the same register bus as lcd_controller/prc; its bus_data_out is OR'd into reg_data_out.
// PARAMETERS
// - BASE_ADDR    24'h2020  first register address (map below)
// - NUM_SOURCES  32        interrupt sources; group g = sources 4g..4g+3; must be a multiple of 4, max 32
// - VECTOR_BASE  8'h03     vector number of source 0; source i -> VECTOR_BASE+i
// PORTS
// - clk             in   1   system clock
// - reset           in   1   asynchronous, active-low reset
// - bus_write       in   1   register bus write strobe (minx write)
// - bus_read        in   1   register bus read strobe (minx read)
// - bus_address_in  in   24  bus address (minx address_out)
// - bus_data_in     in   8   write data (cpu data_out)
// - bus_data_out    out  8   read data; 8'h00 when address not in block
// - irq_sources     in   NUM_SOURCES  source lines; a rising edge requests
// - iack            in   1   CPU interrupt acknowledge pulse
// - irq_level       out  2   0 = none, 1..3 = priority of pending request; minx drives cpu irq = {2'b00, irq_level}
// - irq_vector      out  8   vector number of the current winner (minx muxes it onto data_in during read_interrupt_vector)
// BEHAVIOUR
// - Reset: all flags, enables, priorities and edge-detect history = 0; bus_data_out = 0; irq_level = 0; irq_vector = VECTOR_BASE.
// - Register map (offset from BASE_ADDR), all read/write:
//   - +0..+1  PRI: 2 bits per group, group 0 in bits [1:0] of +0; group 4 in bits [1:0] of +1.
//   - +2..+5  ENA: 1 bit per source, source 0 = bit0 of +2.
//   - +6..+9  FLAG: reads pending flags; writing 1 clears the bit, writing 0 has no effect.
//   - Bits for sources >= NUM_SOURCES read 0 and ignore writes.
// - Bus write: takes effect on the clk edge where bus_write = 1 and the address matches.
// - Bus read: bus_data_out is combinational from address and current registers, gated by bus_read and a match.
// - Edge detect: flag[i] sets on the cycle after irq_sources[i] goes 0->1, independent of enable.
//   - A level held high sets the flag once.
// - Simultaneous set and write-1-clear of the same flag in one cycle: set wins, flag stays 1.
// - Arbitration: candidate i = flag[i] & ena[i] & (pri[grp(i)] != 0).
//   - Winner = highest pri; tie -> lowest index.
// - irq_level/irq_vector are registered from the arbitration result.
//   - Latency: source edge -> flag, 1 cycle; flag -> irq_level, 1 further cycle (2 cycles total).
// - Clear flag, disable source, or zero its group priority: irq_level falls the cycle after the register write.
// - iack: freezes irq_vector (not irq_level) until iack deasserts, so the vector read is stable mid-acknowledge.
//   - Flags are never auto-cleared; software clears them via FLAG.
// - No state machine beyond the iack freeze bit.
// - Reset asserted mid-operation clears everything asynchronously, including pending flags and the freeze bit.
// STRUCTURE
// - Package minx_irq_pkg:
//   - register offsets PRI0, PRI1, ENA0..ENA3, FLAG0..FLAG3;
//   - source index constants IRQ_PRC_COPY = 0, IRQ_PRC_DONE = 1, etc.;
//   - typedef irq_level_t (logic [1:0]).
// - Sub-module irq_arbiter: purely combinational; candidates + priorities -> {valid, level, index}.
// - The top module holds the registers, edge detectors, bus decode and output registers.
// TESTING
// - Reset, then read +0..+9 -> all 8'h00; irq_level 0; irq_vector 8'h03.
// - PRI0 = 8'h03, ENA0 = 8'h01, pulse source 0 -> FLAG0 reads 8'h01 after 1 cycle; irq_level = 3 and irq_vector = 8'h03 after 2 cycles.
// - Sources 1 and 5 pending: group0 pri 1, group1 pri 2 -> vector 8'h08, level 2. Write FLAG0 = 8'h20 -> next cycle vector 8'h04, level 1.
// - Write FLAG0 = 8'h01 on the same cycle source 0 rises -> flag remains 1.
// - Source held high 100 cycles -> one set. Clear it while still high -> stays 0 until a new 0->1 edge.
// - iack high, then raise a higher-priority source -> irq_vector held until iack low, then updates next cycle.
// - Assert reset mid-pending -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/minx_irq_pkg.sv
// Shared constants for the minx interrupt controller: register offsets,
// well-known source numbers and the priority-level type.
package minx_irq_pkg;

    typedef logic [1:0] irq_level_t;

    localparam int NUM_REGS = 10;

    localparam logic [3:0] PRI0  = 4'd0;
    localparam logic [3:0] PRI1  = 4'd1;
    localparam logic [3:0] ENA0  = 4'd2;
    localparam logic [3:0] ENA1  = 4'd3;
    localparam logic [3:0] ENA2  = 4'd4;
    localparam logic [3:0] ENA3  = 4'd5;
    localparam logic [3:0] FLAG0 = 4'd6;
    localparam logic [3:0] FLAG1 = 4'd7;
    localparam logic [3:0] FLAG2 = 4'd8;
    localparam logic [3:0] FLAG3 = 4'd9;

    localparam int IRQ_PRC_COPY = 0;
    localparam int IRQ_PRC_DONE = 1;
    localparam int IRQ_TIMER0   = 2;
    localparam int IRQ_TIMER1   = 3;
    localparam int IRQ_TIMER2   = 4;
    localparam int IRQ_TIMER3   = 5;
    localparam int IRQ_KEY0     = 16;

    // Priority field of the group that owns source src.
    function automatic irq_level_t group_pri(input logic [15:0] pri, input int src);
        return pri[2*(src/4) +: 2];
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection: highest group priority, ties broken
// towards the lowest source index.
module irq_arbiter
    import minx_irq_pkg::*;
(
    input  logic [31:0] cand_i,
    input  logic [15:0] pri_i,
    output logic        valid_o,
    output irq_level_t  level_o,
    output logic [4:0]  index_o
);

    irq_level_t lvl;

    // Strict '>' keeps the earlier (lower) index on equal priority.
    always_comb begin
        valid_o = 1'b0;
        level_o = '0;
        index_o = '0;
        lvl     = '0;
        for (int i = 0; i < 32; i++) begin
            lvl = group_pri(pri_i, i);
            if (cand_i[i] && (lvl > level_o)) begin
                valid_o = 1'b1;
                level_o = lvl;
                index_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching interrupt controller on the minx register bus: flag/enable/
// priority registers, arbitration and registered level/vector to the CPU.
module irq_controller
    import minx_irq_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'h2020,
    parameter int          NUM_SOURCES = 32,
    parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_write,
    input  logic                   bus_read,
    input  logic [23:0]            bus_address_in,
    input  logic [7:0]             bus_data_in,
    output logic [7:0]             bus_data_out,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    input  logic                   iack,
    output irq_level_t             irq_level,
    output logic [7:0]             irq_vector
);

    logic [31:0] src_ext, src_mask, src_grp_on, edge_set, flag_clr, cand;
    logic [31:0] flag_q, flag_d, ena_q, ena_d, prev_q;
    logic [15:0] pri_q, pri_d, pri_mask;
    logic [7:0]  grp_on;
    logic [7:0]  vector_q, vector_d, rd_byte;
    irq_level_t  level_q, level_d;
    logic [23:0] offset;
    logic [3:0]  off;
    logic        hit;
    logic        arb_valid;
    irq_level_t  arb_level;
    logic [4:0]  arb_index;

    always_comb begin
        src_ext = '0;
        src_ext[NUM_SOURCES-1:0] = irq_sources;
    end

    // Unimplemented sources/groups are masked so their bits read 0 and never win.
    for (genvar gi = 0; gi < 32; gi++) begin : g_src
        assign src_mask[gi]   = (gi < NUM_SOURCES);
        assign src_grp_on[gi] = grp_on[gi/4];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        assign pri_mask[2*gi +: 2] = (gi < NUM_SOURCES/4) ? 2'b11 : 2'b00;
        assign grp_on[gi]          = (pri_q[2*gi +: 2] != 2'b00);
    end

    assign offset   = bus_address_in - BASE_ADDR;
    assign hit      = (offset < 24'(NUM_REGS));
    assign off      = offset[3:0];
    assign edge_set = src_ext & ~prev_q & src_mask;
    assign cand     = flag_q & ena_q & src_grp_on;

    always_comb begin
        pri_d    = pri_q;
        ena_d    = ena_q;
        flag_clr = '0;
        if (bus_write && hit) begin
            case (off)
                PRI0:    pri_d[7:0]     = bus_data_in;
                PRI1:    pri_d[15:8]    = bus_data_in;
                ENA0:    ena_d[7:0]     = bus_data_in;
                ENA1:    ena_d[15:8]    = bus_data_in;
                ENA2:    ena_d[23:16]   = bus_data_in;
                ENA3:    ena_d[31:24]   = bus_data_in;
                FLAG0:   flag_clr[7:0]   = bus_data_in;
                FLAG1:   flag_clr[15:8]  = bus_data_in;
                FLAG2:   flag_clr[23:16] = bus_data_in;
                FLAG3:   flag_clr[31:24] = bus_data_in;
                default: ;
            endcase
        end
        pri_d  = pri_d & pri_mask;
        ena_d  = ena_d & src_mask;
        // A new edge in the same cycle as a software clear keeps the flag set.
        flag_d = ((flag_q & ~flag_clr) | edge_set) & src_mask;
    end

    always_comb begin
        case (off)
            PRI0:    rd_byte = pri_q[7:0];
            PRI1:    rd_byte = pri_q[15:8];
            ENA0:    rd_byte = ena_q[7:0];
            ENA1:    rd_byte = ena_q[15:8];
            ENA2:    rd_byte = ena_q[23:16];
            ENA3:    rd_byte = ena_q[31:24];
            FLAG0:   rd_byte = flag_q[7:0];
            FLAG1:   rd_byte = flag_q[15:8];
            FLAG2:   rd_byte = flag_q[23:16];
            FLAG3:   rd_byte = flag_q[31:24];
            default: rd_byte = 8'h00;
        endcase
        bus_data_out = (bus_read && hit) ? rd_byte : 8'h00;
    end

    irq_arbiter u_arbiter (
        .cand_i  (cand),
        .pri_i   (pri_q),
        .valid_o (arb_valid),
        .level_o (arb_level),
        .index_o (arb_index)
    );

    // The vector stays frozen while iack is high so the CPU reads a stable value.
    assign level_d  = arb_valid ? arb_level : '0;
    assign vector_d = iack ? vector_q : (VECTOR_BASE + {3'b000, arb_index});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q   <= '0;
            ena_q    <= '0;
            pri_q    <= '0;
            prev_q   <= '0;
            level_q  <= '0;
            vector_q <= VECTOR_BASE;
        end else begin
            flag_q   <= flag_d;
            ena_q    <= ena_d;
            pri_q    <= pri_d;
            prev_q   <= src_ext & src_mask;
            level_q  <= level_d;
            vector_q <= vector_d;
        end
    end

    assign irq_level  = level_q;
    assign irq_vector = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller: a register-level model
// predicts bus reads and the registered level/vector cycle by cycle.
module tb_irq_controller;

    localparam logic [23:0] B  = 24'h2020;
    localparam logic [7:0]  VB = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_write = 1'b0, bus_read = 1'b0, iack = 1'b0;
    logic [23:0] bus_address_in = '0;
    logic [7:0]  bus_data_in = '0;
    logic [7:0]  bus_data_out;
    logic [31:0] irq_sources = '0;
    logic [1:0]  irq_level;
    logic [7:0]  irq_vector;

    irq_controller #(.BASE_ADDR(B), .NUM_SOURCES(32), .VECTOR_BASE(VB)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_sources    (irq_sources),
        .iack           (iack),
        .irq_level      (irq_level),
        .irq_vector     (irq_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] lvl;
        logic [7:0] vec;
        bit         rd;
        logic [7:0] rd_exp;
        logic [23:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    // Reference model state: one entry per source / group.
    bit         m_flag[32];
    bit         m_ena[32];
    bit         m_prev[32];
    bit   [1:0] m_pri[8];
    logic [1:0] m_level;
    logic [7:0] m_vector;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_flag[i] = 0; m_ena[i] = 0; m_prev[i] = 0;
        end
        for (int g = 0; g < 8; g++) m_pri[g] = 0;
        m_level  = 2'd0;
        m_vector = VB;
    endtask

    function automatic logic [7:0] model_read(input int off);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (off <= 1 && k < 4)       b[2*k +: 2] = m_pri[4*off + k];
            else if (off >= 2 && off <= 5) b[k] = m_ena[8*(off-2) + k];
            else if (off >= 6 && off <= 9) b[k] = m_flag[8*(off-6) + k];
        end
        return b;
    endfunction

    // Highest priority first, then lowest index within that priority.
    task automatic arbitrate(output bit v, output int lvl, output int idx);
        v = 0; lvl = 0; idx = 0;
        for (int p = 3; p >= 1; p--) begin
            for (int i = 0; i < 32; i++) begin
                if (!v && m_flag[i] && m_ena[i] && m_pri[i/4] == p) begin
                    v = 1; lvl = p; idx = i;
                end
            end
        end
    endtask

    task automatic cycle(input bit w, input bit r, input logic [23:0] a,
                         input logic [7:0] d, input logic [31:0] src, input bit ack);
        exp_t        e;
        bit          v, inblk;
        int          lvl, idx, off;
        logic [31:0] clr;
        @(posedge clk);
        #2;
        bus_write = w; bus_read = r; bus_address_in = a;
        bus_data_in = d; irq_sources = src; iack = ack;
        inblk    = (a >= B) && (a < B + 24'd10);
        off      = int'(a - B);
        e.lvl    = m_level;
        e.vec    = m_vector;
        e.rd     = r;
        e.addr   = a;
        e.rd_exp = (r && inblk) ? model_read(off) : 8'h00;
        sb_q.push_back(e);

        arbitrate(v, lvl, idx);
        m_level = v ? 2'(lvl) : 2'd0;
        if (!ack) m_vector = VB + 8'(idx);
        clr = '0;
        if (w && inblk) begin
            if (off <= 1) for (int k = 0; k < 4; k++) m_pri[4*off + k] = d[2*k +: 2];
            else if (off <= 5) for (int k = 0; k < 8; k++) m_ena[8*(off-2) + k] = d[k];
            else clr[8*(off-6) +: 8] = d;
        end
        for (int i = 0; i < 32; i++) begin
            m_flag[i] = (m_flag[i] && !clr[i]) || (src[i] && !m_prev[i]);
            m_prev[i] = src[i];
        end
    endtask

    task automatic nop(input logic [31:0] src);
        cycle(0, 0, 24'h0, 8'h00, src, 0);
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d addr=%06h rd=%0d lvl=%0d vec=%02h data=%02h",
                         txn, e.addr, e.rd, irq_level, irq_vector, bus_data_out);
                check("irq_level", 8'(irq_level), 8'(e.lvl));
                check("irq_vector", irq_vector, e.vec);
                if (e.rd) check("bus_data_out", bus_data_out, e.rd_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s;
        logic [23:0] a;
        s = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset values of every register plus an out-of-block read.
        for (int i = 0; i < 10; i++) cycle(0, 1, B + 24'(i), 8'h00, s, 0);
        cycle(0, 1, B + 24'd10, 8'h00, s, 0);

        // Single source, full latency path.
        cycle(1, 0, B + 0, 8'h03, s, 0);
        cycle(1, 0, B + 2, 8'h01, s, 0);
        s = 32'h1; nop(s);
        s = 32'h0; cycle(0, 1, B + 6, 8'h00, s, 0);
        nop(s); nop(s);
        cycle(1, 0, B + 6, 8'h01, s, 0);
        nop(s); nop(s);

        // Sources 1 and 5 at different group priorities, then clear the winner.
        cycle(1, 0, B + 0, 8'h09, s, 0);
        cycle(1, 0, B + 2, 8'h22, s, 0);
        s = 32'h22; nop(s); nop(s); nop(s);
        cycle(1, 0, B + 6, 8'h20, s, 0);
        nop(s); cycle(0, 1, B + 6, 8'h00, s, 0);

        // Clear and new edge in the same cycle: the edge wins.
        s = 32'h0; nop(s);
        s = 32'h1; cycle(1, 0, B + 6, 8'h01, s, 0);
        cycle(0, 1, B + 6, 8'h00, s, 0);

        // Level held high sets once; clearing while high stays clear.
        cycle(1, 0, B + 2, 8'h2B, s, 0);
        s = s | 32'h8;
        for (int i = 0; i < 100; i++) cycle(0, (i % 10) == 0, B + 6, 8'h00, s, 0);
        cycle(1, 0, B + 6, 8'h08, s, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, B + 6, 8'h00, s, 0);
        s = s & ~32'h8; nop(s);
        s = s | 32'h8; nop(s); cycle(0, 1, B + 6, 8'h00, s, 0);

        // iack freezes the vector while a higher-priority source arrives.
        cycle(1, 0, B + 6, 8'hFF, s, 0);
        s = 32'h0; nop(s);
        s = 32'h2; nop(s); nop(s); nop(s);
        cycle(0, 0, 24'h0, 8'h00, s, 1);
        s = 32'h22;
        for (int i = 0; i < 5; i++) cycle(0, 0, 24'h0, 8'h00, s, 1);
        nop(s); nop(s); nop(s);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            a = B - 24'd2 + 24'($urandom_range(0, 14));
            s = s ^ ($urandom & $urandom & $urandom);
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), a,
                  8'($urandom), s, ($urandom_range(0, 7) == 0));
        end

        // Make a request pending, then reset asynchronously mid-cycle.
        cycle(1, 0, B + 0, 8'h03, s, 0);
        cycle(1, 0, B + 2, 8'hFF, s, 0);
        s = s & ~32'h1; nop(s);
        s = s | 32'h1; nop(s); nop(s); nop(s);
        repeat (2) @(negedge clk);
        check("queue_drained", 8'(sb_q.size()), 8'd0);
        check("pre_reset_level", 8'(irq_level), 8'(m_level));
        @(posedge clk);
        #3;
        bus_read = 1'b1; bus_address_in = B + 6;
        rst_n = 1'b0;
        #1;
        check("reset_level", 8'(irq_level), 8'h00);
        check("reset_vector", irq_vector, VB);
        check("reset_flag_read", bus_data_out, 8'h00);
        bus_read = 1'b0; irq_sources = '0; s = '0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, 1, B + 24'(i), 8'h00, s, 0);
        nop(s);
        repeat (2) @(negedge clk);
        check("final_queue_drained", 8'(sb_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
